// File: rtl/fetch_pipe_ctrl_pkg.sv
// fetch_pipe_ctrl_pkg: shared constants for the fetch stage (NOP encoding, FSM states, PC step)
package fetch_pipe_ctrl_pkg;
    localparam logic [31:0] NOP         = 32'h0;
    localparam int          PC_STEP_DEF = 4;
    localparam logic [1:0]  ST_INIT     = 2'd0;
    localparam logic [1:0]  ST_RUN      = 2'd1;
    localparam logic [1:0]  ST_STALL    = 2'd2;
endpackage

// File: rtl/fetch_pipe_ctrl_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, bubble and hold.
//   clk, rst_n      clock, async active-low reset
//   load_i          capture {inst_i, pc_plus4_i} as a valid instruction
//   bubble_i        insert NOP with valid=0 (wins over load_i)
//   inst_o, pc_plus4_o, valid_o   register contents
module if_id_reg
    import fetch_pipe_ctrl_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  bubble_i,
    input  logic [INST_WIDTH-1:0] inst_i,
    input  logic [PC_WIDTH-1:0]   pc_plus4_i,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [PC_WIDTH-1:0]   pc_plus4_o,
    output logic                  valid_o
);
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [PC_WIDTH-1:0]   pc_plus4_q, pc_plus4_d;
    logic                  valid_q, valid_d;

    always_comb begin
        inst_d     = bubble_i ? INST_WIDTH'(NOP) : load_i ? inst_i     : inst_q;
        pc_plus4_d = bubble_i ? '0               : load_i ? pc_plus4_i : pc_plus4_q;
        valid_d    = bubble_i ? 1'b0             : load_i ? 1'b1       : valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q     <= INST_WIDTH'(NOP);
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            inst_q     <= inst_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign inst_o     = inst_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;
endmodule

// File: rtl/fetch_pipe_ctrl.sv
// fetch_pipe_ctrl: PC, IF/ID register and INIT/RUN/STALL control honouring hazard-unit stall/flush.
//   clk, rst_n                     clock, async active-low reset
//   pc_write, inst_ld              hazard unit advance permissions (must agree)
//   flush, flush_target            redirect from a taken jump/branch in ID
//   imem_addr, imem_rdata          instruction memory (combinational read)
//   pc_init                        one-cycle pulse when fetch starts after reset
//   if_id_inst/pc_plus4/valid      IF/ID register
//   hs_err                         sticky pc_write/inst_ld disagreement
//   perf_stall_cnt, perf_flush_cnt saturating counters, built only with FETCH_PERF_EN
module fetch_pipe_ctrl
    import fetch_pipe_ctrl_pkg::*;
#(
    parameter int                  PC_WIDTH   = 32,
    parameter int                  INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter int                  PC_STEP    = PC_STEP_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pc_write,
    input  logic                  inst_ld,
    input  logic                  flush,
    input  logic [PC_WIDTH-1:0]   flush_target,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic                  pc_init,
    output logic [INST_WIDTH-1:0] if_id_inst,
    output logic [PC_WIDTH-1:0]   if_id_pc_plus4,
    output logic                  if_id_valid,
    output logic                  hs_err,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt
);
    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d, pc_next;
    logic                pc_init_q, hs_err_q, hs_err_d;
    logic                run, do_flush, advance, stall;

    // Flush outranks everything; any non-advancing combination (including a
    // mismatch) holds PC and IF/ID so no instruction is lost.
    always_comb begin
        run      = state_q != ST_INIT;
        pc_next  = pc_q + PC_WIDTH'(PC_STEP);
        do_flush = run && flush;
        advance  = run && !flush && pc_write && inst_ld;
        stall    = run && !flush && !(pc_write && inst_ld);
        pc_d     = do_flush ? flush_target : advance ? pc_next : pc_q;
        state_d  = stall ? ST_STALL : ST_RUN;
        hs_err_d = hs_err_q || (stall && (pc_write ^ inst_ld));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            pc_q      <= RESET_PC;
            pc_init_q <= 1'b0;
            hs_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pc_init_q <= !run;
            hs_err_q  <= hs_err_d;
        end
    end

    if_id_reg #(.PC_WIDTH(PC_WIDTH), .INST_WIDTH(INST_WIDTH)) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (advance),
        .bubble_i   (do_flush || !run),
        .inst_i     (imem_rdata),
        .pc_plus4_i (pc_next),
        .inst_o     (if_id_inst),
        .pc_plus4_o (if_id_pc_plus4),
        .valid_o    (if_id_valid)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (do_flush && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

    assign imem_addr = pc_q;
    assign pc_init   = pc_init_q;
    assign hs_err    = hs_err_q;
endmodule
